// File: rtl/scancode_matrix_mapper.sv
// Scan events to an active-low ROWSxCOLS key matrix with a CPU-writable keymap.
// SCANMAP_RELEASE_TRACK_EN: a release reuses the modifiers held at press time.
module scancode_matrix_mapper #(
  parameter int ROWS    = 8,
  parameter int COLS    = 5,
  parameter int PLANES  = 2,
  parameter int MODBITS = 3,
  parameter int CS_ROW  = 0,
  parameter int CS_COL  = 0,
  parameter int SS_ROW  = 7,
  parameter int SS_COL  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_received,
  input  logic [6:0]         scan,
  input  logic               extended,
  input  logic               released,
  input  logic [MODBITS-1:0] modifiers,
  input  logic               caps_shift,
  input  logic               sym_shift,
  input  logic               kbclean,
  input  logic [ROWS-1:0]    sp_row,
  output logic [COLS-1:0]    sp_col,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic               rewind,
  output logic               overrun
);
  localparam int PB    = $clog2(PLANES);
  localparam int IW    = MODBITS + 8;
  localparam int AW    = IW + PB;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [3:0] {
    CLEAN, IDLE, HOLD, FETCH, APPLY,
    CPU_ADDR, CPU_RD, CPU_WR, CPU_WAIT
  } state_t;

  state_t state, state_d;

  logic [7:0]         map_q [PLANES][DEPTH];
  logic [COLS-1:0]    rows_q [ROWS];
  logic [7:0]         ent_q [PLANES];

  logic               pend_v;
  logic [6:0]         pend_scan;
  logic               pend_ext;
  logic               pend_rel;
  logic [MODBITS-1:0] pend_mods;
  logic [6:0]         ev_scan;
  logic               ev_ext;
  logic               ev_rel;
  logic [MODBITS-1:0] ev_mods;
  logic [MODBITS-1:0] idx_mods;
  logic [IW-1:0]      idx_q;
  logic [PB-1:0]      pl_q;
  logic [AW-1:0]      cpuaddr;
  logic               take;

  logic [PB-1:0]      cpu_pl;
  logic [IW-1:0]      cpu_ent;
  logic [7:0]         ent;
  logic [2:0]         ent_row;
  logic [COLS-1:0]    ent_mask;
  logic               ent_ok;

  assign take     = (state == IDLE) && pend_v;
  assign cpu_pl   = cpuaddr[PB-1:0];
  assign cpu_ent  = cpuaddr[AW-1:PB];
  assign ent      = ent_q[pl_q];
  assign ent_row  = ent[COLS+2:COLS];
  assign ent_mask = ent[COLS-1:0];
  assign ent_ok   = (|ent_mask) && (int'(ent_row) < ROWS);

`ifdef SCANMAP_RELEASE_TRACK_EN
  logic [MODBITS-1:0] held_q [256];
  logic [7:0]         key;

  assign key      = {ev_ext, ev_scan};
  assign idx_mods = ev_rel ? held_q[key] : ev_mods;

  always_ff @(posedge clk) begin
    if (!rst && state == HOLD && !ev_rel)
      held_q[key] <= ev_mods;
  end
`else
  assign idx_mods = ev_mods;
`endif

  always_comb begin
    state_d = state;
    case (state)
      CLEAN: state_d = IDLE;
      IDLE: begin
        if (pend_v)
          state_d = HOLD;
        else if (kbclean)
          state_d = CLEAN;
        else if (rewind || cpu_read || cpu_write)
          state_d = CPU_ADDR;
      end
      HOLD:  state_d = FETCH;
      FETCH: state_d = APPLY;
      APPLY: begin
        if (pl_q == PB'(PLANES - 1))
          state_d = IDLE;
      end
      CPU_ADDR: begin
        if (rewind)
          state_d = IDLE;
        else if (cpu_read)
          state_d = CPU_RD;
        else if (cpu_write)
          state_d = CPU_WR;
        else
          state_d = IDLE;
      end
      CPU_RD:   state_d = CPU_WAIT;
      CPU_WR:   state_d = CPU_WAIT;
      CPU_WAIT: begin
        if (!cpu_read && !cpu_write)
          state_d = IDLE;
      end
      default:  state_d = CLEAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAN;
      pend_v    <= 1'b0;
      pend_scan <= '0;
      pend_ext  <= 1'b0;
      pend_rel  <= 1'b0;
      pend_mods <= '0;
      ev_scan   <= '0;
      ev_ext    <= 1'b0;
      ev_rel    <= 1'b0;
      ev_mods   <= '0;
      idx_q     <= '0;
      pl_q      <= '0;
      cpuaddr   <= '0;
      cpu_dout  <= 8'h00;
      overrun   <= 1'b0;
      for (int p = 0; p < PLANES; p++)
        ent_q[p] <= 8'h00;
    end else begin
      state   <= state_d;
      overrun <= scan_received && pend_v && !take;
      // a strobe landing on the consume cycle refills the slot
      if (scan_received && (!pend_v || take)) begin
        pend_v    <= 1'b1;
        pend_scan <= scan;
        pend_ext  <= extended;
        pend_rel  <= released;
        pend_mods <= modifiers;
      end else if (take) begin
        pend_v <= 1'b0;
      end
      if (take) begin
        ev_scan <= pend_scan;
        ev_ext  <= pend_ext;
        ev_rel  <= pend_rel;
        ev_mods <= pend_mods;
      end
      if (state == HOLD)
        idx_q <= {idx_mods, ev_ext, ev_scan};
      if (state == FETCH) begin
        pl_q <= '0;
        for (int p = 0; p < PLANES; p++)
          ent_q[p] <= map_q[p][idx_q];
      end
      if (state == APPLY)
        pl_q <= pl_q + 1'b1;
      if (state == CPU_ADDR && rewind)
        cpuaddr <= '0;
      if (state == CPU_WAIT && !cpu_read && !cpu_write)
        cpuaddr <= cpuaddr + 1'b1;
      if (state == CPU_RD)
        cpu_dout <= map_q[cpu_pl][cpu_ent];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == CPU_WR)
      map_q[cpu_pl][cpu_ent] <= cpu_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        rows_q[r] <= '1;
    end else begin
      if (state == CLEAN) begin
        for (int r = 0; r < ROWS; r++)
          rows_q[r] <= '1;
      end else if (state == APPLY && ent_ok) begin
        if (ev_rel)
          rows_q[ent_row] <= rows_q[ent_row] | ent_mask;
        else
          rows_q[ent_row] <= rows_q[ent_row] & ~ent_mask;
      end
      // shift overlay keys always win over the keymap
      rows_q[CS_ROW][CS_COL] <= ~caps_shift;
      rows_q[SS_ROW][SS_COL] <= ~sym_shift;
    end
  end

  always_comb begin
    sp_col = '1;
    for (int r = 0; r < ROWS; r++)
      if (!sp_row[r])
        sp_col = sp_col & rows_q[r];
  end

endmodule

// File: tb/tb_scancode_matrix_mapper.sv
// Directed self-checking bench for scancode_matrix_mapper (default parameters).
// Expectations for the modifier-tracking case follow SCANMAP_RELEASE_TRACK_EN.
module tb_scancode_matrix_mapper;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_received = 1'b0;
  logic [6:0] scan = '0;
  logic       extended = 1'b0;
  logic       released = 1'b0;
  logic [2:0] modifiers = '0;
  logic       caps_shift = 1'b0;
  logic       sym_shift = 1'b0;
  logic       kbclean = 1'b0;
  logic [7:0] sp_row = 8'h00;
  logic [4:0] sp_col;
  logic [7:0] cpu_din = 8'h00;
  logic [7:0] cpu_dout;
  logic       cpu_read = 1'b0;
  logic       cpu_write = 1'b0;
  logic       rewind = 1'b0;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int ov_cnt = 0;
  int addr = 0;

  always #5 clk = ~clk;

  scancode_matrix_mapper dut (
    .clk(clk), .rst(rst),
    .scan_received(scan_received), .scan(scan),
    .extended(extended), .released(released),
    .modifiers(modifiers),
    .caps_shift(caps_shift), .sym_shift(sym_shift),
    .kbclean(kbclean),
    .sp_row(sp_row), .sp_col(sp_col),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .rewind(rewind), .overrun(overrun)
  );

  always @(negedge clk)
    if (overrun === 1'b1) ov_cnt++;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_op(input logic rd, input logic wr,
                        input logic [7:0] d);
    @(negedge clk);
    cpu_read = rd; cpu_write = wr; cpu_din = d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0;
    repeat (2) @(posedge clk);
    addr = (addr + 1) % 4096;
  endtask

  task automatic do_rewind();
    @(negedge clk) rewind = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rewind = 1'b0;
    @(posedge clk);
    addr = 0;
  endtask

  task automatic goto_addr(input int target);
    while (addr != target) cpu_op(1'b1, 1'b0, 8'h00);
  endtask

  task automatic key(input logic [6:0] s, input logic r,
                     input logic [2:0] m);
    @(negedge clk);
    scan = s; extended = 1'b0; released = r; modifiers = m;
    scan_received = 1'b1;
    @(posedge clk);
    #1 scan_received = 1'b0;
  endtask

  task automatic clean();
    @(negedge clk) kbclean = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) kbclean = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sp_col", 8'(sp_col), 8'h1F);
    chk("rst_dout", cpu_dout, 8'h00);
    chk("rst_overrun", 8'(overrun), 8'h00);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // keymap port: write, rewind, read back in order
    do_rewind();
    cpu_op(1'b0, 1'b1, 8'hAB);
    cpu_op(1'b0, 1'b1, 8'hCD);
    do_rewind();
    cpu_op(1'b1, 1'b0, 8'h00);
    #1 chk("rd_plane0", cpu_dout, 8'hAB);
    cpu_op(1'b1, 1'b0, 8'h00);
    #1 chk("rd_plane1", cpu_dout, 8'hCD);

    // 0x1C, 0x1D, 0x1E (mods 000) then 0x1E with shift
    goto_addr(12'h038);
    cpu_op(1'b0, 1'b1, 8'h21);
    cpu_op(1'b0, 1'b1, 8'h00);
    cpu_op(1'b0, 1'b1, 8'h04);
    cpu_op(1'b0, 1'b1, 8'h82);
    cpu_op(1'b0, 1'b1, 8'h68);
    cpu_op(1'b0, 1'b1, 8'h00);
    goto_addr(12'h23C);
    cpu_op(1'b0, 1'b1, 8'h44);
    cpu_op(1'b0, 1'b1, 8'h00);

    // single-plane press/release with latency
    @(negedge clk) sp_row = 8'hFD;
    key(7'h1C, 1'b0, 3'b000);
    repeat (3) @(posedge clk);
    #1 chk("p1_edge3", 8'(sp_col), 8'h1F);
    @(posedge clk);
    #1 chk("p1_edge4", 8'(sp_col), 8'h1E);
    key(7'h1C, 1'b1, 3'b000);
    repeat (4) @(posedge clk);
    #1 chk("r1_edge4", 8'(sp_col), 8'h1F);
    repeat (2) @(posedge clk);

    // realtime overlay keys
    @(negedge clk) begin sp_row = 8'hFE; caps_shift = 1'b1; end
    @(posedge clk);
    #1 chk("caps_shift", 8'(sp_col), 8'h1E);
    @(negedge clk) begin sp_row = 8'h7F; caps_shift = 1'b0; sym_shift = 1'b1; end
    @(posedge clk);
    #1 chk("sym_shift", 8'(sp_col), 8'h1D);
    @(negedge clk) sym_shift = 1'b0;
    @(posedge clk);

    // two planes land on consecutive cycles
    @(negedge clk) sp_row = 8'hEE;
    key(7'h1D, 1'b0, 3'b000);
    repeat (4) @(posedge clk);
    #1 chk("p2_plane0", 8'(sp_col), 8'h1B);
    @(posedge clk);
    #1 chk("p2_plane1", 8'(sp_col), 8'h19);
    key(7'h1D, 1'b1, 3'b000);
    repeat (4) @(posedge clk);
    #1 chk("r2_plane0", 8'(sp_col), 8'h1D);
    @(posedge clk);
    #1 chk("r2_plane1", 8'(sp_col), 8'h1F);
    repeat (2) @(posedge clk);

    // press with shift, release after shift was let go
    @(negedge clk) sp_row = 8'hF3;
    key(7'h1E, 1'b0, 3'b001);
    repeat (5) @(posedge clk);
    #1 chk("shift_press", 8'(sp_col), 8'h1B);
    key(7'h1E, 1'b1, 3'b000);
    repeat (5) @(posedge clk);
`ifdef SCANMAP_RELEASE_TRACK_EN
    #1 chk("shift_release", 8'(sp_col), 8'h1F);
`else
    #1 chk("shift_release", 8'(sp_col), 8'h1B);
`endif
    clean();
    #1 chk("kbclean", 8'(sp_col), 8'h1F);

    // three back-to-back strobes: third one dropped
    @(negedge clk) begin sp_row = 8'hE4; ov_cnt = 0; end
    @(negedge clk) begin
      scan = 7'h1C; released = 1'b0; modifiers = 3'b000;
      scan_received = 1'b1;
    end
    @(negedge clk) scan = 7'h1D;
    @(negedge clk) scan = 7'h1E;
    @(negedge clk) scan_received = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("ovr_pulses", 8'(ov_cnt), 8'h01);
    chk("ovr_matrix", 8'(sp_col), 8'h18);
    clean();
    @(negedge clk) sp_row = 8'h00;
    @(posedge clk);
    #1 chk("ovr_clean", 8'(sp_col), 8'h1F);

    // address wraps from the top entry to zero
    goto_addr(4095);
    cpu_op(1'b0, 1'b1, 8'h5A);
    cpu_op(1'b1, 1'b0, 8'h00);
    #1 chk("addr_wrap", cpu_dout, 8'hAB);

    // reset in the middle of APPLY
    @(negedge clk) sp_row = 8'hEE;
    key(7'h1D, 1'b0, 3'b000);
    repeat (4) @(posedge clk);
    #1 chk("mid_plane0", 8'(sp_col), 8'h1B);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("mid_rst_col", 8'(sp_col), 8'h1F);
    chk("mid_rst_ovr", 8'(overrun), 8'h00);
    chk("mid_rst_dout", cpu_dout, 8'h00);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("post_rst_col", 8'(sp_col), 8'h1F);
    addr = 0;
    cpu_op(1'b1, 1'b0, 8'h00);
    #1 chk("post_rst_addr", cpu_dout, 8'hAB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
